// File: rtl/paged_count_display.sv
// paged_count_display: run/stop cycle counter with a paged BCD display front end.
// A debounced push-button toggles counting. Once per display cycle the count is
// snapshotted and converted to BCD with a shift-add-3 engine. The digits are then
// shown GROUP at a time, starting with a blank page.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module paged_count_display #(
    parameter int unsigned CNT_W      = 36,
    parameter int unsigned DIGITS     = 12,
    parameter int unsigned GROUP      = 3,
    parameter int unsigned PAGE_DIV   = 25_000_000,
    parameter int unsigned DEB_CYCLES = 500_000,
    localparam int unsigned PAGES     = DIGITS / GROUP,
    localparam int unsigned PW        = $clog2(PAGES + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_btn_n,
    input  logic                 i_clr,
    output logic                 o_running,
    output logic [CNT_W-1:0]     o_count,
    output logic [4*GROUP-1:0]   o_disp_bcd,
    output logic [PW-1:0]        o_page,
    output logic                 o_bcd_valid
);

    localparam int unsigned DW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned PRE_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
    localparam int unsigned IT_W  = $clog2(CNT_W + 1);
    localparam int unsigned BW    = 4 * DIGITS;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } conv_state_e;

    // Button path
    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb_level;
    logic          r_deb_prev;
    logic [DW-1:0] r_deb_cnt;
    logic          w_press;

    // Counter
    logic             r_running;
    logic [CNT_W-1:0] r_count;

    // Prescaler and pages
    logic [PRE_W-1:0] r_pre;
    logic             w_page_tick;
    logic [PW-1:0]    r_page;
    logic [PW-1:0]    w_page_d;
    logic             w_snap_go;

    // Converter
    conv_state_e      r_state;
    conv_state_e      w_state_d;
    logic             w_load;
    logic [CNT_W-1:0] r_shreg;
    logic [BW-1:0]    r_bcd;
    logic [BW-1:0]    w_bcd_adj;
    logic [IT_W-1:0]  r_iter;
    logic [BW-1:0]    r_bcd_snap;
    logic             r_bcd_valid;

    // Display
    logic [BW-1:0]        w_shown;
    logic [4*GROUP-1:0]   w_disp_d;
    logic [4*GROUP-1:0]   r_disp;

    // Synchronise the raw button and accept a new level only after it has held steady
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_deb_level <= 1'b1;
            r_deb_prev  <= 1'b1;
            r_deb_cnt   <= '0;
        end else begin
            r_sync1    <= i_btn_n;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb_level;
            if (r_sync2 == r_deb_level) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
                r_deb_level <= r_sync2;
                r_deb_cnt   <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    // A press is the debounced level falling from released to pressed
    assign w_press = r_deb_prev & ~r_deb_level;

    // Run/stop toggle and the cycle counter; clear wins over increment
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_running <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_press) begin
                r_running <= ~r_running;
            end
            if (i_clr) begin
                r_count <= '0;
            end else if (r_running) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign w_page_tick = (r_pre == PRE_W'(PAGE_DIV - 1));

    // Free-running page prescaler
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre <= '0;
        end else if (w_page_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Next page: blank, then most significant group down to group 0, then blank again
    always_comb begin
        w_page_d = r_page;
        if (w_page_tick) begin
            if (r_page == PW'(0)) begin
                w_page_d = PW'(PAGES);
            end else begin
                w_page_d = r_page - 1'b1;
            end
        end
    end

    // Snapshot on the tick that moves from group 0 into the blank page
    assign w_snap_go = w_page_tick && (r_page == PW'(0));

    // Converter state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Converter next state; a snapshot is only taken while idle
    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_snap_go) begin
                    w_state_d = StShift;
                    w_load    = 1'b1;
                end
            end
            StShift: begin
                if (r_iter == IT_W'(CNT_W - 1)) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Add 3 to every BCD nibble of 5 or more before the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter datapath: load, shift CNT_W times, then publish the result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg     <= '0;
            r_bcd       <= '0;
            r_iter      <= '0;
            r_bcd_snap  <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            if (w_load) begin
                r_shreg <= r_count;
                r_bcd   <= '0;
                r_iter  <= '0;
            end else if (r_state == StShift) begin
                {r_bcd, r_shreg} <= {w_bcd_adj, r_shreg} << 1;
                r_iter           <= r_iter + 1'b1;
            end else if (r_state == StDone) begin
                r_bcd_snap  <= r_bcd;
                r_bcd_valid <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_nz_seen;

    // Blank every digit above the most significant non-zero one; digit 0 always shows
    always_comb begin
        w_shown   = r_bcd_snap;
        w_nz_seen = 1'b0;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (r_bcd_snap[4*i +: 4] != 4'h0) begin
                w_nz_seen = 1'b1;
            end
            if (!w_nz_seen) begin
                w_shown[4*i +: 4] = 4'hF;
            end
        end
    end
`else
    assign w_shown = r_bcd_snap;
`endif

    // Select the group for the upcoming page; the blank page shows all 4'hF
    always_comb begin
        w_disp_d = {GROUP{4'hF}};
        for (int k = 0; k < int'(PAGES); k++) begin
            if (w_page_d == PW'(k)) begin
                w_disp_d = w_shown[4*GROUP*k +: 4*GROUP];
            end
        end
    end

    // Page and display registers move together, one cycle after the tick
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_page <= PW'(PAGES);
            r_disp <= {GROUP{4'hF}};
        end else begin
            r_page <= w_page_d;
            r_disp <= w_disp_d;
        end
    end

    assign o_running   = r_running;
    assign o_count     = r_count;
    assign o_disp_bcd  = r_disp;
    assign o_page      = r_page;
    assign o_bcd_valid = r_bcd_valid;

endmodule

// File: tb/tb_paged_count_display.sv
// Self-checking bench for paged_count_display with a small configuration.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_paged_count_display;

    localparam int CNT_W    = 8;
    localparam int DIGITS   = 3;
    localparam int GROUP    = 1;
    localparam int PAGE_DIV = 16;
    localparam int DEB      = 4;
    localparam int PAGES    = DIGITS / GROUP;
    localparam int PW       = $clog2(PAGES + 1);
    localparam int DCYC     = PAGE_DIV * (PAGES + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                btn_n;
    logic                clr;
    logic                running;
    logic [CNT_W-1:0]    count;
    logic [4*GROUP-1:0]  disp_bcd;
    logic [PW-1:0]       page;
    logic                bcd_valid;

    always #5 clk = ~clk;

    paged_count_display #(
        .CNT_W      (CNT_W),
        .DIGITS     (DIGITS),
        .GROUP      (GROUP),
        .PAGE_DIV   (PAGE_DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_n     (btn_n),
        .i_clr       (clr),
        .o_running   (running),
        .o_count     (count),
        .o_disp_bcd  (disp_bcd),
        .o_page      (page),
        .o_bcd_valid (bcd_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: values the DUT should hold in cycle m_cyc
    int m_cyc = 0;
    int m_count = 0;
    bit m_running = 1'b0;
    bit b_hist [0:16383];
    bit l_hist [0:16383];

    typedef struct {
        int val;
        int due;
    } snap_t;
    snap_t exp_q[$];
    int    shown = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, m_cyc,
                     $time);
        end
    endtask

    function automatic int page_of(input int c);
        return PAGES - ((c / PAGE_DIV) % (PAGES + 1));
    endfunction

    // Synchronised button as seen by the debouncer in cycle m
    function automatic bit sync_of(input int m);
        return (m < 2) ? 1'b1 : b_hist[m-2];
    endfunction

    function automatic bit lvl_of(input int m);
        return (m < 0) ? 1'b1 : l_hist[m];
    endfunction

    function automatic logic [3:0] exp_disp(input int pg, input int val);
        int p10 = 1;
        for (int i = 0; i < pg; i++) p10 = p10 * 10;
        if (pg == PAGES) return 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        if (pg > 0 && val < p10) return 4'hF;
`endif
        return 4'((val / p10) % 10);
    endfunction

    function automatic int next_blank_tick(input int from);
        int t = from;
        while (t % DCYC != DCYC - 1) t++;
        return t;
    endfunction

    // Drive one cycle of inputs at the falling edge and advance the model past the next edge
    task automatic step(input bit b, input bit c, input bit r);
        bit lvl_next;
        bit stable;
        bit press;
        btn_n = b;
        clr   = c;
        rst   = r;
        if (r) begin
            m_cyc     = 0;
            m_count   = 0;
            m_running = 1'b0;
            l_hist[0] = 1'b1;
        end else begin
            b_hist[m_cyc] = b;
            if (m_cyc % PAGE_DIV == PAGE_DIV - 1 && page_of(m_cyc) == 0)
                exp_q.push_back('{val: m_count, due: m_cyc + CNT_W + 2});
            stable = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (sync_of(m_cyc - j) == lvl_of(m_cyc)) stable = 1'b0;
            lvl_next = stable ? ~lvl_of(m_cyc) : lvl_of(m_cyc);
            press    = lvl_of(m_cyc - 1) && !lvl_of(m_cyc);
            if (c) m_count = 0;
            else if (m_running) m_count = (m_count + 1) % (1 << CNT_W);
            if (press) m_running = ~m_running;
            m_cyc++;
            l_hist[m_cyc] = lvl_next;
        end
        @(negedge clk);
    endtask

    task automatic run_until(input int target);
        while (m_cyc < target) step(btn_n, 1'b0, 1'b0);
    endtask

    task automatic press_btn();
        repeat (10) step(1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compares every cycle and pops the scoreboard on each bcd_valid pulse
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("rst_running", running, 0);
                check("rst_count", count, 0);
                check("rst_page", page, PAGES);
                check("rst_disp", disp_bcd, 4'hF);
                check("rst_valid", bcd_valid, 0);
                exp_q.delete();
                shown = 0;
            end else begin
                check("count", count, m_count);
                check("running", running, m_running);
                check("page", page, page_of(m_cyc));
                if (bcd_valid) begin
                    if (exp_q.size() == 0) begin
                        check("bcd_valid_unexpected", bcd_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("bcd_valid_cycle", m_cyc, e.due);
                        shown = e.val;
                    end
                end else if (exp_q.size() > 0 && exp_q[0].due <= m_cyc) begin
                    check("bcd_valid_missing", bcd_valid, 1);
                    void'(exp_q.pop_front());
                end
                check("disp_bcd", disp_bcd, exp_disp(page_of(m_cyc), shown));
            end
        end
    end

    initial begin
        int f;
        int t;
        int seen;
        bit cur;
        int hold;
        logic [3:0] lz_exp;
        rst   = 1'b1;
        btn_n = 1'b1;
        clr   = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        check("init_running", running, 0);
        check("init_count", count, 0);
        check("init_page", page, PAGES);

        // Short glitch must be ignored
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0);
        check("glitch_running", running, 0);

        // Clean press: running toggles exactly 7 cycles after the fall
        f = m_cyc;
        step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        check("press_cyc6_running", running, 0);
        check("press_cyc6_index", m_cyc - f, 6);
        step(1'b0, 1'b0, 1'b0);
        check("press_cyc7_running", running, 1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0);
        press_btn();
        check("second_press_running", running, 0);
        press_btn();
        check("third_press_running", running, 1);

        // Count 255 at the blank-entry tick: wrap, conversion latency, pages 2,5,5
        t = next_blank_tick(m_cyc + 260);
        run_until(t - 256);
        step(1'b1, 1'b1, 1'b0);
        run_until(t);
        check("snap_count_255", count, 255);
        step(1'b1, 1'b0, 1'b0);
        check("wrap_to_zero", count, 0);
        run_until(t + CNT_W + 1);
        check("valid_not_early", bcd_valid, 0);
        step(1'b1, 1'b0, 1'b0);
        check("valid_on_time", bcd_valid, 1);
        run_until(t + 17);
        check("p2_page", page, 2);
        check("p2_digit", disp_bcd, 2);
        run_until(t + 33);
        check("p1_digit", disp_bcd, 5);
        run_until(t + 49);
        check("p0_digit", disp_bcd, 5);
        run_until(t + 65);
        check("blank_page", page, PAGES);
        check("blank_disp", disp_bcd, 4'hF);

        // Clear while running: count zero, running unchanged
        step(1'b1, 1'b1, 1'b0);
        check("clr_count", count, 0);
        check("clr_running", running, 1);

        // Snapshot of 7: leading digits blank or zero depending on the build
`ifdef LEADING_ZERO_BLANK_EN
        lz_exp = 4'hF;
`else
        lz_exp = 4'h0;
`endif
        t = next_blank_tick(m_cyc + 20);
        run_until(t - 8);
        step(1'b1, 1'b1, 1'b0);
        run_until(t);
        check("snap_count_7", count, 7);
        run_until(t + 17);
        check("lz_p2", disp_bcd, lz_exp);
        run_until(t + 33);
        check("lz_p1", disp_bcd, lz_exp);
        run_until(t + 49);
        check("lz_p0", disp_bcd, 7);

        // Random button activity and clears against the model
        cur  = 1'b1;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                cur  = ~cur;
                hold = $urandom_range(1, 12);
            end
            hold--;
            step(cur, ($urandom_range(0, 15) == 0), 1'b0);
        end
        repeat (12) step(1'b1, 1'b0, 1'b0);

        // Reset during a conversion: result is dropped
        t = next_blank_tick(m_cyc + 5);
        run_until(t + 4);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("midrst_page", page, PAGES);
        check("midrst_disp", disp_bcd, 4'hF);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bcd_valid) seen++;
        end
        check("midrst_no_valid", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/paged_count_display.md
# paged_count_display

Parametrised run/stop event counter with a paged BCD display front end. The block debounces a start/stop push-button and counts clock cycles while running. Each display cycle it snapshots the count and converts it to BCD with a sequential shift-add-3 engine. It then presents the digits to a narrow 7-segment bank GROUP digits at a time, starting with a blank page. It sits between board I/O and the BCD_2_7Seg decoders, and generalises the fixed 36-bit / 3-digit / 4-page arrangement used at top level.

## Interface
- CNT_W, 36: counter width in bits.
- DIGITS, 12: BCD digits produced. Must satisfy 10^DIGITS > 2^CNT_W − 1 and be a multiple of GROUP.
- GROUP, 3: digits shown per page, i.e. the number of physical 7-segment displays.
- PAGE_DIV, 25_000_000: clk cycles per page. Must be > CNT_W + 2.
- DEB_CYCLES, 500_000: cycles the synchronised button must be stable before it is accepted.
- Derived: PAGES = DIGITS/GROUP; PW = $clog2(PAGES+1).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_n  in  1  raw start/stop button, active-low, asynchronous to clk.
- clr  in  1  synchronous clear of the counter.
- running  out  1  1 while counting.
- count  out  CNT_W  live counter value.
- disp_bcd  out  4*GROUP  BCD nibbles of the current page, most significant digit in the top nibble; 4'hF means blank.
- page  out  PW  current page: PAGES = blank page; k = digits [GROUP*(k+1)−1 : GROUP*k].
- bcd_valid  out  1  one-cycle pulse when a new snapshot conversion completes.

## Operation
- **Button path**
  - btn_n passes through a 2-FF synchroniser, then a debouncer.
  - The debounced level updates only after DEB_CYCLES consecutive equal samples.
  - A debounced 1→0 transition (press) toggles running.
- **Counter**
  - clr=1 sets count to 0; clr has priority over increment and does not change running.
  - Otherwise, running=1 increments count by 1 per cycle.
  - count wraps from 2^CNT_W−1 to 0.
- **Prescaler**
  - Counts 0..PAGE_DIV−1 and free-runs regardless of running.
  - Asserts page_tick in the cycle it holds PAGE_DIV−1.
- **Page sequencer**
  - On page_tick: BLANK(PAGES) → PAGES−1 → … → 0 → BLANK.
- **Snapshot**
  - On the page_tick that enters BLANK, count is captured into the converter shift register.
  - A conversion in progress is never restarted. This cannot occur given the PAGE_DIV constraint.
- **Converter FSM**
  - IDLE: wait for a snapshot.
  - SHIFT: CNT_W iterations. Each iteration first adds 3 to every BCD nibble ≥ 5, then shifts left one bit.
  - DONE: load bcd_snap, pulse bcd_valid, return to IDLE.
- **Display mux**
  - BLANK page: disp_bcd is all 4'hF.
  - Page k: disp_bcd is the slice of bcd_snap for group k.
  - The display always shows the last completed snapshot, never the live count.
- **Reset values** (all outputs and internal state)
  - running=0, count=0, page=PAGES, disp_bcd all 4'hF, bcd_valid=0.
  - bcd_snap=0, prescaler=0, converter=IDLE.
  - Debounced level = 1 (released); synchroniser flops = 1.
- **Reset mid-operation**
  - Aborts any conversion and returns to reset values on the next edge.

## Timing
- btn_n falling edge to running toggle: 2 synchroniser cycles + DEB_CYCLES + 1 cycle.
- Snapshot value: count as registered in the page_tick cycle that enters BLANK.
- bcd_valid: asserted CNT_W+2 cycles after that tick (1 load + CNT_W shifts + 1 DONE).
- bcd_snap: updates in the same cycle bcd_valid is asserted.
- page, disp_bcd: registered; both update the cycle after page_tick.
- One full display cycle = (PAGES+1) × PAGE_DIV clocks.
- clr in the same cycle as the snapshot capture: the snapshot takes the pre-clear value.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - On digit pages, every digit of bcd_snap above the most significant non-zero digit is shown as 4'hF.
  - Digit 0 is never blanked, so value 0 shows as "0" on page 0 only.
  - Pages consisting entirely of blanked digits output all 4'hF but are still stepped through.
- LEADING_ZERO_BLANK_EN undefined:
  - Leading zeros are displayed as 4'h0.

## Test plan
Bench parameters: CNT_W=8, DIGITS=3, GROUP=1, PAGE_DIV=16, DEB_CYCLES=4.
- **Reset:** rst high 2 cycles → running=0, count=0, page=3, disp_bcd=4'hF, bcd_valid=0.
- **Debounce:** btn_n glitch low for 3 cycles → running stays 0. Then low for 10 cycles → running=1 exactly 7 cycles after the fall. Release then press again → running=0.
- **Conversion and paging:** force count=255 at the BLANK-entry tick → bcd_valid 10 cycles later. Pages then show 2, 5, 5 (page 2→0), then blank.
- **Wrap and clear:** count=255 with running=1 → next cycle 0. clr asserted together with running → count=0 and running unchanged.
- **Leading-zero blanking:** snapshot=7 with LEADING_ZERO_BLANK_EN → pages show F, F, 7. Without the macro → 0, 0, 7.
- **Reset mid-operation:** rst during SHIFT → bcd_valid never pulses for that snapshot, disp_bcd=4'hF, page=3.
